hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-only controller: consumes per-instruction T_use/T_new/dest info from the D-stage decoder.
- Holds a shift-register scoreboard of in-flight writers, one entry per stage after D (default E, M, W).
- Issues D-stage stall and forwarding selects.
- Adds a multi-cycle mult/div busy counter that interlocks HI/LO users.

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_md_counter.sv | 39 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: register/tnew encodings, forwarding and MDU defaults.
// Scoreboard entry layout, MSB first: {valid, addr[REG_ADDR_W-1:0], tnew[TNEW_W-1:0], md_start, md_is_div}.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam int TNEW_W_DEF = 2;

  // Decoder encodings at the default width; all-ones on a tuse field means the operand is never read.
  typedef enum logic [TNEW_W_DEF-1:0] {
    TNEW_JAL   = 2'd0,
    TNEW_ALU   = 2'd1,
    TNEW_LOAD  = 2'd2,
    TUSE_NEVER = 2'd3
  } tnew_code_e;

  localparam int FWD_RF = 0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/hazard_md_counter.sv
// Mult/div busy counter: loads the unit latency while an md op sits in E, then counts down to idle.
module hazard_md_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: shift-register scoreboard of in-flight writers driving stall and forward selects.
// Define HAZARD_STATS_EN to add the stall_cnt / md_stall_cnt statistics outputs.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int TNEW_W      = TNEW_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int FSEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  D_valid,
  input  logic [REG_ADDR_W-1:0] D_rs,
  input  logic [REG_ADDR_W-1:0] D_rt,
  input  logic [TNEW_W-1:0]     D_tuse_rs,
  input  logic [TNEW_W-1:0]     D_tuse_rt,
  input  logic [REG_ADDR_W-1:0] D_wr_addr,
  input  logic [TNEW_W-1:0]     D_tnew,
  input  logic                  D_md_start,
  input  logic                  D_md_is_div,
  input  logic                  D_md_use,
  output logic                  stall,
  output logic [FSEL_W-1:0]     fwd_rs_sel,
  output logic [FSEL_W-1:0]     fwd_rt_sel,
  output logic                  md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           md_stall_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [TNEW_W-1:0]     tnew;
    logic                  md_start;
    logic                  md_is_div;
  } sb_entry_t;

  sb_entry_t [NUM_STAGES:1] sb_q, sb_d;

  logic [NUM_STAGES:1] rs_match, rt_match;
  logic                rs_hit, rt_hit;
  logic [FSEL_W-1:0]   rs_sel, rt_sel;
  logic [TNEW_W-1:0]   rs_tnew, rt_tnew;
  logic                rs_stall, rt_stall, md_stall;

  for (genvar gi = 1; gi <= NUM_STAGES; gi++) begin : g_match
    assign rs_match[gi] = sb_q[gi].valid && (sb_q[gi].addr == D_rs) && (D_rs != REG_ZERO);
    assign rt_match[gi] = sb_q[gi].valid && (sb_q[gi].addr == D_rt) && (D_rt != REG_ZERO);
  end

  // Scan oldest to youngest so the lowest matching stage is the one that sticks.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_sel  = FSEL_W'(FWD_RF);
    rt_sel  = FSEL_W'(FWD_RF);
    rs_tnew = '0;
    rt_tnew = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (rs_match[k]) begin
        rs_hit  = 1'b1;
        rs_sel  = FSEL_W'(k);
        rs_tnew = sb_q[k].tnew;
      end
      if (rt_match[k]) begin
        rt_hit  = 1'b1;
        rt_sel  = FSEL_W'(k);
        rt_tnew = sb_q[k].tnew;
      end
    end
  end

  assign rs_stall = rs_hit && (D_tuse_rs != '1) && (rs_tnew > D_tuse_rs);
  assign rt_stall = rt_hit && (D_tuse_rt != '1) && (rt_tnew > D_tuse_rt);
  assign md_stall = D_md_use && (md_busy || sb_q[1].md_start);
  assign stall    = D_valid && (rs_stall || rt_stall || md_stall);

  assign fwd_rs_sel = rs_sel;
  assign fwd_rt_sel = rt_sel;

  // Only entry 1 sees stall; older entries simply age with a saturating tnew countdown.
  always_comb begin
    sb_d[1] = '0;
    if (D_valid && !stall) begin
      sb_d[1].valid     = 1'b1;
      sb_d[1].addr      = D_wr_addr;
      sb_d[1].tnew      = D_tnew;
      sb_d[1].md_start  = D_md_start;
      sb_d[1].md_is_div = D_md_is_div;
    end
    for (int k = 2; k <= NUM_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
      if (sb_q[k-1].tnew != '0) begin
        sb_d[k].tnew = sb_q[k-1].tnew - TNEW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // MDU flags leaving the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = sb_q[NUM_STAGES].md_start ^ sb_q[NUM_STAGES].md_is_div;

  hazard_md_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (sb_q[1].md_start),
    .is_div_i (sb_q[1].md_is_div),
    .busy_o   (md_busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, md_stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (D_valid && md_stall) begin
        md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus randomized instruction streams.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int N    = 3;
  localparam int TW   = 2;
  localparam int FW   = 2;
  localparam int MULT = 5;
  localparam int DIV  = 10;
  localparam int NEV  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          D_valid = 1'b0;
  logic [4:0]    D_rs = '0, D_rt = '0, D_wr_addr = '0;
  logic [TW-1:0] D_tuse_rs = '0, D_tuse_rt = '0, D_tnew = '0;
  logic          D_md_start = 1'b0, D_md_is_div = 1'b0, D_md_use = 1'b0;
  logic          stall, md_busy;
  logic [FW-1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_cnt, md_stall_cnt;
`endif

  hazard_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .D_valid     (D_valid),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_tuse_rs   (D_tuse_rs),
    .D_tuse_rt   (D_tuse_rt),
    .D_wr_addr   (D_wr_addr),
    .D_tnew      (D_tnew),
    .D_md_start  (D_md_start),
    .D_md_is_div (D_md_is_div),
    .D_md_use    (D_md_use),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .md_busy     (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rs, rt, tuse_rs, tuse_rt, wr, tnew;
    bit mds, mdd, mdu;
  } instr_t;

  typedef struct {
    bit stall, busy;
    int rs_sel, rt_sel;
  } exp_t;

  // A writer that entered E in cycle e sits in stage (now - e + 1).
  typedef struct {
    int e, addr, tnew;
  } wr_t;

  exp_t exp_q[$];
  wr_t  hist[$];
  int   cyc = 0;
  bit   md_act = 0;
  int   md_e = 0, md_len = 0;
  int   n_checks = 0, n_fail = 0;
  int   exp_stall_cnt = 0, exp_md_cnt = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic instr_t mk(input bit v, input int rs, input int rt, input int tur, input int tut,
                                input int wr, input int tn, input bit mds, input bit mdd, input bit mdu);
    instr_t d;
    d.valid = v; d.rs = rs; d.rt = rt; d.tuse_rs = tur; d.tuse_rt = tut;
    d.wr = wr; d.tnew = tn; d.mds = mds; d.mdd = mdd; d.mdu = mdu;
    return d;
  endfunction

  // Youngest in-flight writer of src and its remaining latency at this cycle.
  function automatic void youngest(input int src, output int sel, output int tn);
    sel = 0;
    tn  = 0;
    if (src == 0) return;
    foreach (hist[i]) begin
      int st;
      st = cyc - hist[i].e + 1;
      if (st >= 1 && st <= N && hist[i].addr == src && (sel == 0 || st < sel)) begin
        sel = st;
        tn  = (hist[i].tnew > st - 1) ? hist[i].tnew - (st - 1) : 0;
      end
    end
  endfunction

  function automatic exp_t predict(input instr_t d, output bit md_st);
    exp_t x;
    int rs_sel, rs_tn, rt_sel, rt_tn, diff;
    bit rs_st, rt_st;
    youngest(d.rs, rs_sel, rs_tn);
    youngest(d.rt, rt_sel, rt_tn);
    rs_st  = rs_sel != 0 && d.tuse_rs != NEV && rs_tn > d.tuse_rs;
    rt_st  = rt_sel != 0 && d.tuse_rt != NEV && rt_tn > d.tuse_rt;
    diff   = cyc - md_e;
    x.busy = md_act && diff >= 1 && diff <= md_len;
    md_st  = d.mdu && md_act && diff >= 0 && diff <= md_len;
    x.stall  = d.valid && (rs_st || rt_st || md_st);
    x.rs_sel = rs_sel;
    x.rt_sel = rt_sel;
    return x;
  endfunction

  task automatic apply(input instr_t d);
    D_valid = d.valid; D_rs = 5'(d.rs); D_rt = 5'(d.rt);
    D_tuse_rs = TW'(d.tuse_rs); D_tuse_rt = TW'(d.tuse_rt);
    D_wr_addr = 5'(d.wr); D_tnew = TW'(d.tnew);
    D_md_start = d.mds; D_md_is_div = d.mdd; D_md_use = d.mdu;
  endtask

  // One D-stage cycle: drive, queue the expectation, advance the reference model.
  task automatic run_cycle(input instr_t d, output bit dut_st, output int dut_rs, output int dut_rt,
                           output bit exp_st);
    exp_t x;
    bit md_st;
    apply(d);
    x = predict(d, md_st);
    exp_q.push_back(x);
    if (x.stall) exp_stall_cnt++;
    if (d.valid && md_st) exp_md_cnt++;
    if (d.valid && !x.stall) begin
      wr_t w;
      w.e = cyc + 1; w.addr = d.wr; w.tnew = d.tnew;
      hist.push_back(w);
      if (d.mds) begin
        md_act = 1; md_e = cyc + 1; md_len = d.mdd ? DIV : MULT;
      end
    end
    @(negedge clk);
    dut_st = stall; dut_rs = int'(fwd_rs_sel); dut_rt = int'(fwd_rt_sel);
    @(posedge clk);
    #1;
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].e + 1 > N) void'(hist.pop_front());
    exp_st = x.stall;
  endtask

  // Hold an instruction in D until the model says it leaves; report DUT stall cycles seen.
  task automatic issue(input instr_t d, output int nst, output int rs_a, output int rt_a);
    bit ds, es;
    nst = 0; rs_a = 0; rt_a = 0;
    for (int i = 0; i < 64; i++) begin
      run_cycle(d, ds, rs_a, rt_a, es);
      if (ds) nst++;
      if (!es) return;
    end
    check("issue_timeout", 1, 0);
  endtask

  task automatic bubbles(input int n);
    int ns, a, b;
    for (int i = 0; i < n; i++) issue(mk(0, 0, 0, NEV, NEV, 0, 0, 0, 0, 0), ns, a, b);
  endtask

  // Monitor: every presented cycle is compared against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("stall", int'(stall), int'(x.stall));
        check("md_busy", int'(md_busy), int'(x.busy));
        if (!x.stall) begin
          check("fwd_rs_sel", int'(fwd_rs_sel), x.rs_sel);
          check("fwd_rt_sel", int'(fwd_rt_sel), x.rt_sel);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ns, ra, rb, wait_n;
    instr_t d;

    // Reset state
    #3;
    check("reset_stall", int'(stall), 0);
    check("reset_md_busy", int'(md_busy), 0);
    check("reset_fwd_rs", int'(fwd_rs_sel), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: load-use
    issue(mk(1, 0, 0, NEV, NEV, 8, int'(TNEW_LOAD), 0, 0, 0), ns, ra, rb);
    issue(mk(1, 8, 8, 1, 1, 9, int'(TNEW_ALU), 0, 0, 0), ns, ra, rb);
    $display("scenario lw-use: stalls=%0d rs_sel=%0d rt_sel=%0d", ns, ra, rb);
    check("s1_stalls", ns, 1);
    check("s1_fwd_rs", ra, 2);
    check("s1_fwd_rt", rb, 2);
    bubbles(3);

    // 2: ALU result into branch
    issue(mk(1, 0, 0, NEV, NEV, 8, int'(TNEW_ALU), 0, 0, 0), ns, ra, rb);
    issue(mk(1, 8, 0, 0, 0, 0, int'(TNEW_JAL), 0, 0, 0), ns, ra, rb);
    $display("scenario alu-branch: stalls=%0d rs_sel=%0d rt_sel=%0d", ns, ra, rb);
    check("s2_stalls", ns, 1);
    check("s2_fwd_rs", ra, 2);
    check("s2_fwd_rt", rb, 0);
    bubbles(3);

    // 3: two writers of $8, youngest wins
    issue(mk(1, 0, 0, NEV, NEV, 8, int'(TNEW_ALU), 0, 0, 0), ns, ra, rb);
    issue(mk(1, 0, 0, NEV, NEV, 8, int'(TNEW_JAL), 0, 0, 0), ns, ra, rb);
    issue(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0), ns, ra, rb);
    $display("scenario youngest: stalls=%0d rs_sel=%0d", ns, ra);
    check("s3_stalls", ns, 0);
    check("s3_fwd_rs", ra, 1);
    bubbles(3);

    // 5: async reset mid-divide with a live writer in E
    issue(mk(1, 0, 0, NEV, NEV, 0, 0, 1, 1, 1), ns, ra, rb);
    bubbles(6);
    issue(mk(1, 0, 0, NEV, NEV, 5, int'(TNEW_ALU), 0, 0, 0), ns, ra, rb);
    apply(mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 1));
    #1;
    check("prereset_md_busy", int'(md_busy), 1);
    check("prereset_fwd_rs", int'(fwd_rs_sel), 1);
    check("prereset_stall", int'(stall), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_stall", int'(stall), 0);
    check("async_rst_md_busy", int'(md_busy), 0);
    check("async_rst_fwd_rs", int'(fwd_rs_sel), 0);
    check("async_rst_fwd_rt", int'(fwd_rt_sel), 0);
    @(negedge clk);
    @(negedge clk);
    check("held_rst_md_busy", int'(md_busy), 0);
    check("held_rst_fwd_rs", int'(fwd_rs_sel), 0);
`ifdef HAZARD_STATS_EN
    check("rst_stall_cnt", int'(stall_cnt), 0);
    check("rst_md_stall_cnt", int'(md_stall_cnt), 0);
`endif
    hist.delete();
    md_act = 0;
    exp_stall_cnt = 0;
    exp_md_cnt = 0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    issue(mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0), ns, ra, rb);
    $display("scenario async-reset: post stalls=%0d rs_sel=%0d", ns, ra);
    check("postrst_stalls", ns, 0);
    check("postrst_fwd_rs", ra, 0);

    // 4: div then mflo, mult then mfhi
    issue(mk(1, 0, 0, NEV, NEV, 0, 0, 1, 1, 1), ns, ra, rb);
    issue(mk(1, 0, 0, NEV, NEV, 3, int'(TNEW_ALU), 0, 0, 1), ns, ra, rb);
    $display("scenario div-mflo: stalls=%0d", ns);
    check("div_mflo_stalls", ns, DIV + 1);
`ifdef HAZARD_STATS_EN
    check("div_stall_cnt", int'(stall_cnt), DIV + 1);
    check("div_md_stall_cnt", int'(md_stall_cnt), DIV + 1);
`endif
    bubbles(2);
    issue(mk(1, 0, 0, NEV, NEV, 0, 0, 1, 0, 1), ns, ra, rb);
    issue(mk(1, 0, 0, NEV, NEV, 4, int'(TNEW_ALU), 0, 0, 1), ns, ra, rb);
    $display("scenario mult-mfhi: stalls=%0d", ns);
    check("mult_mfhi_stalls", ns, MULT + 1);
    bubbles(3);

    // Randomized stream over a small register set to provoke overlaps
    for (int i = 0; i < 500; i++) begin
      d.valid   = ($urandom_range(0, 99) < 85);
      d.rs      = $urandom_range(0, 3);
      d.rt      = $urandom_range(0, 3);
      d.tuse_rs = $urandom_range(0, 3);
      d.tuse_rt = $urandom_range(0, 3);
      d.wr      = $urandom_range(0, 3);
      d.tnew    = $urandom_range(0, 3);
      d.mds     = ($urandom_range(0, 15) == 0);
      d.mdd     = $urandom_range(0, 1);
      d.mdu     = d.mds || ($urandom_range(0, 9) == 0);
      issue(d, ns, ra, rb);
    end
    bubbles(2);

`ifdef HAZARD_STATS_EN
    check("final_stall_cnt", int'(stall_cnt), exp_stall_cnt);
    check("final_md_stall_cnt", int'(md_stall_cnt), exp_md_cnt);
`endif

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
